sar_search4: RTL and testbench

SAR_SEARCH4 -- requirements
Module: sar_search4

---
 rtl/sar_search4.sv | 141 ++++++++++++++
 tb/tb_sar_search4.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sar_search4.sv
// Successive-approximation code search driving an external magnitude comparator.
// Latency: start-to-done = WIDTH+1 cycles with an always-ready comparator; fewer with early exit.
// Backpressure: each trial is held with trial_valid high until cmp_valid; start ignored unless IDLE.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 request a new search (accepted only in IDLE)
//   trial, trial_valid    candidate code offered to the comparator, held until a response
//   cmp_valid, cmp_eq/gt/lt  comparator response: trial ==, >, < hidden reference
//   busy                  search in progress
//   done                  one-cycle completion pulse
//   result                final code, held from done until the next completed search
//   found, err            an eq response was seen / a malformed (non-one-hot) response was seen
//
// Build option: define SAR_EARLY_EXIT_EN to finish a search as soon as cmp_eq is accepted.
// Without it every search issues exactly WIDTH trials.

module sar_search4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    output logic             trial_valid,
    input  logic             cmp_valid,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [PW-1:0]    ptr;

    logic [WIDTH-1:0] ptr_bit;
    logic [WIDTH-1:0] next_bit;
    logic [WIDTH-1:0] acc_next;
    logic             resp_onehot;
    logic             last_bit;
    logic             early_hit;

    assign ptr_bit     = {{(WIDTH-1){1'b0}}, 1'b1} << ptr;
    assign next_bit    = ptr_bit >> 1;
    // A "greater" answer means the trial bit overshoots the reference, so it is dropped.
    assign acc_next    = cmp_gt ? (acc & ~ptr_bit) : (acc | ptr_bit);
    assign resp_onehot = $onehot({cmp_eq, cmp_gt, cmp_lt});
    assign last_bit    = (ptr == '0);

`ifdef SAR_EARLY_EXIT_EN
    assign early_hit = cmp_eq;
`else
    assign early_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            ptr         <= '0;
            trial       <= '0;
            trial_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            found       <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= ISSUE;
                        acc         <= '0;
                        ptr         <= PW'(WIDTH-1);
                        found       <= 1'b0;
                        err         <= 1'b0;
                        trial       <= {1'b1, {(WIDTH-1){1'b0}}};
                        trial_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (cmp_valid) begin
                        if (!resp_onehot) begin
                            // Garbage answer: abandon the search, keep only the bits already resolved.
                            err         <= 1'b1;
                            result      <= acc & ~ptr_bit;
                            state       <= DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            trial_valid <= 1'b0;
                            trial       <= '0;
                        end else begin
                            acc <= acc_next;
                            if (cmp_eq) begin
                                found <= 1'b1;
                            end
                            if (last_bit || early_hit) begin
                                // On an early eq, acc_next equals the current trial.
                                result      <= acc_next;
                                state       <= DONE;
                                done        <= 1'b1;
                                busy        <= 1'b0;
                                trial_valid <= 1'b0;
                                trial       <= '0;
                            end else begin
                                ptr   <= ptr - PW'(1);
                                trial <= acc_next | next_bit;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search4.sv
// Directed bench for sar_search4 (WIDTH=4) with a behavioural comparator.
// Latency: n/a (testbench).
// Backpressure: comparator answers can be stalled a fixed number of cycles per trial.

module tb_sar_search4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] trial;
    logic       trial_valid;
    logic       cmp_valid;
    logic       cmp_eq;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       found;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    sar_search4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .trial       (trial),
        .trial_valid (trial_valid),
        .cmp_valid   (cmp_valid),
        .cmp_eq      (cmp_eq),
        .cmp_gt      (cmp_gt),
        .cmp_lt      (cmp_lt),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .found       (found),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk(tag, "trial",       trial,       8'd0);
        chk(tag, "trial_valid", trial_valid, 8'd0);
        chk(tag, "busy",        busy,        8'd0);
        chk(tag, "done",        done,        8'd0);
        chk(tag, "result",      result,      8'd0);
        chk(tag, "found",       found,       8'd0);
        chk(tag, "err",         err,         8'd0);
    endtask

    // Runs one search from IDLE. exp_tr lists the expected trials, first one in [15:12].
    // bad_at selects the trial index answered with a malformed gt+lt response (-1: none).
    task automatic do_search(input string tag, input int refv, input int stall, input int n_exp,
                             input logic [15:0] exp_tr, input logic [3:0] exp_res,
                             input logic exp_found, input int bad_at);
        int         idx;
        int         cyc;
        logic [3:0] t_exp;
        logic [3:0] held;
        idx = 0;
        cyc = 0;
        start = 1'b1;
        step();
        cyc++;
        start = 1'b0;
        for (int g = 0; g < 5; g++) begin
            if (idx < 4) t_exp = exp_tr[15 - 4*idx -: 4];
            else         t_exp = 4'hx;
            chk(tag, "trial_valid", trial_valid, 8'd1);
            chk(tag, "trial",       trial,       t_exp);
            held = trial;
            for (int s = 0; s < stall; s++) begin
                cmp_valid = 1'b0;
                start     = 1'b1;
                step();
                cyc++;
                start = 1'b0;
                chk(tag, "stall_trial", trial,       held);
                chk(tag, "stall_valid", trial_valid, 8'd1);
            end
            cmp_valid = 1'b1;
            if (idx == bad_at) begin
                cmp_eq = 1'b0; cmp_gt = 1'b1; cmp_lt = 1'b1;
            end else begin
                cmp_eq = (int'(held) == refv);
                cmp_gt = (int'(held) >  refv);
                cmp_lt = (int'(held) <  refv);
            end
            step();
            cyc++;
            cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
            idx++;
            if (done === 1'b1) break;
        end
        chk(tag, "trial_count", 8'(idx), 8'(n_exp));
        chk(tag, "latency",     8'(cyc), 8'(1 + n_exp*(stall+1)));
        chk(tag, "done",        done,        8'd1);
        chk(tag, "result",      result,      exp_res);
        chk(tag, "found",       found,       exp_found);
        chk(tag, "err",         err,         (bad_at >= 0) ? 8'd1 : 8'd0);
        chk(tag, "busy",        busy,        8'd0);
        chk(tag, "trial_valid_end", trial_valid, 8'd0);
        // start during the DONE cycle must be ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk(tag, "done_pulse",  done,   8'd0);
        chk(tag, "idle_busy",   busy,   8'd0);
        chk(tag, "result_held", result, exp_res);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmp_valid = 1'b0;
        cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;
        step();

        // Comparator response in IDLE must do nothing
        cmp_valid = 1'b1; cmp_eq = 1'b1;
        step();
        cmp_valid = 1'b0; cmp_eq = 1'b0;
        chk("idle_cmp", "busy",  busy,  8'd0);
        chk("idle_cmp", "done",  done,  8'd0);
        chk("idle_cmp", "found", found, 8'd0);

        do_search("ref11", 11, 0, 4, 16'h8CAB, 4'd11, 1'b1, -1);
`ifdef SAR_EARLY_EXIT_EN
        do_search("ref8",  8,  0, 1, 16'h8000, 4'd8,  1'b1, -1);
`else
        do_search("ref8",  8,  0, 4, 16'h8CA9, 4'd8,  1'b1, -1);
`endif
        do_search("ref0",  0,  0, 4, 16'h8421, 4'd0,  1'b0, -1);
        do_search("ref15", 15, 0, 4, 16'h8CEF, 4'd15, 1'b1, -1);
        do_search("ref3",  3,  0, 4, 16'h8423, 4'd3,  1'b1, -1);
        do_search("stall11", 11, 3, 4, 16'h8CAB, 4'd11, 1'b1, -1);
        do_search("stall5",  5,  3, 4, 16'h8465, 4'd5,  1'b1, -1);
        do_search("bad11",   11, 0, 2, 16'h8C00, 4'd8,  1'b0, 1);

        // Reset in the middle of a search, colliding with start and a response
        start = 1'b1;
        step();
        start = 1'b0;
        cmp_valid = 1'b1; cmp_lt = 1'b1;
        step();
        cmp_lt = 1'b0; cmp_gt = 1'b1;
        step();
        cmp_valid = 1'b0; cmp_gt = 1'b0;
        chk("midrst", "third_trial", trial, 8'd10);
        rst = 1'b1; start = 1'b1; cmp_valid = 1'b1; cmp_gt = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; cmp_valid = 1'b0; cmp_gt = 1'b0;
        chk_reset_state("midrst");
        step();
        chk("midrst", "still_idle", busy, 8'd0);
        do_search("after_rst", 11, 0, 4, 16'h8CAB, 4'd11, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
